shm_arbiter: RTL and testbench

- Round-robin arbiter and burst sequencer for the single-port shared memory (SHM).
- Multiplexes fixed-length bursts from NREQ requesters (e.g. MOVE/PRE_LOAD read path, elementwise writeback, host loader) onto SHM.
- Generates the per-beat SHM addresses itself, then routes read data back to the owning requester.
- Sits between the controller-driven units and the SHM macro; replaces direct SHM_en driving.

---
 rtl/shm_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_shm_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shm_arbiter.sv
// shm_arbiter: round-robin arbiter and burst sequencer for the single-port SHM.
// Grants fixed-length bursts to NREQ requesters, generates the per-beat SHM
// addresses, and routes read data back to the owning requester.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   req/wr/base_addr    per-requester burst request, direction, start address
//   wdata               per-requester write data, one word per beat
//   gnt, beat, done     burst owner (one-hot), beat strobe, end-of-burst pulse
//   rvalid, rdata       read data return to the owner
//   shm_*               SHM macro interface (shm_rdata RD_LAT cycles after ren)
//
// Optional build macro SHM_ARB_STATS_EN adds stat_clr, stat_bursts and
// stat_conflict (saturating per-requester burst and contention counters).

module shm_arbiter #(
    parameter int NREQ   = 3,
    parameter int AW     = 6,
    parameter int DW     = 32,
    parameter int BURST  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr,
    input  logic [NREQ*AW-1:0] base_addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              beat,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic              shm_ren,
    output logic              shm_wen,
    output logic [AW-1:0]     shm_addr,
    output logic [DW-1:0]     shm_wdata,
    input  logic [DW-1:0]     shm_rdata
`ifdef SHM_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [NREQ*16-1:0] stat_bursts,
    output logic [15:0]       stat_conflict
`endif
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int DCW = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [NREQ-1:0]     gnt_q;
    logic [PW-1:0]       owner_q;
    logic [PW-1:0]       ptr_q;
    logic                wr_q;
    logic [AW-1:0]       base_q;
    logic [BW-1:0]       beat_cnt_q;
    logic [DCW-1:0]      drain_cnt_q;
    logic [NREQ-1:0]     done_q;
    logic [NREQ-1:0]     rvalid_q;
    logic [DW-1:0]       rdata_q;
    logic [NREQ-1:0]     tag_q [RD_LAT];

    logic                grant;
    logic                finish;
    logic                found;
    logic [PW:0]         idx_ext;
    logic [PW-1:0]       win_idx;
    logic [NREQ-1:0]     win_oh;

    // First requester at or after ptr_q, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        idx_ext = '0;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_ext = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx_ext >= (PW+1)'(NREQ))
                idx_ext = idx_ext - (PW+1)'(NREQ);
            if (!found && req[idx_ext[PW-1:0]]) begin
                found   = 1'b1;
                win_idx = idx_ext[PW-1:0];
            end
        end
        win_oh = NREQ'(1) << win_idx;
    end

    // Next-state logic. The drain lasts until the last read word has been
    // registered onto rvalid/rdata, so done follows the final rvalid.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant   = 1'b1;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (beat_cnt_q == BW'(BURST - 1)) begin
                    if (wr_q) begin
                        finish  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DCW'(RD_LAT)) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            wr_q        <= 1'b0;
            base_q      <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            done_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= finish ? gnt_q : '0;
            if (grant) begin
                gnt_q      <= win_oh;
                owner_q    <= win_idx;
                wr_q       <= wr[win_idx];
                base_q     <= base_addr[win_idx*AW +: AW];
                beat_cnt_q <= '0;
            end else begin
                if (finish)
                    gnt_q <= '0;
                if (state_q == S_BURST)
                    beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (state_q == S_DRAIN)
                drain_cnt_q <= drain_cnt_q + 1'b1;
            else
                drain_cnt_q <= '0;
            // Finishing owner drops to lowest priority for the next round.
            if (finish) begin
                if (owner_q == PW'(NREQ - 1))
                    ptr_q <= '0;
                else
                    ptr_q <= owner_q + 1'b1;
            end
        end
    end

    // Read return: owner tag travels alongside the SHM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++)
                tag_q[i] <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            tag_q[0] <= shm_ren ? gnt_q : '0;
            for (int i = 1; i < RD_LAT; i++)
                tag_q[i] <= tag_q[i-1];
            rvalid_q <= tag_q[RD_LAT-1];
            rdata_q  <= (|tag_q[RD_LAT-1]) ? shm_rdata : '0;
        end
    end

    assign gnt       = gnt_q;
    assign beat      = (state_q == S_BURST);
    assign done      = done_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign shm_wen   = beat & wr_q;
    assign shm_ren   = beat & ~wr_q;
    assign shm_addr  = beat ? base_q + AW'(beat_cnt_q) : '0;
    assign shm_wdata = shm_wen ? wdata[owner_q*DW +: DW] : '0;

`ifdef SHM_ARB_STATS_EN
    logic [15:0] bursts_q [NREQ];
    logic [15:0] conflict_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++)
                bursts_q[i] <= '0;
            conflict_q <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NREQ; i++)
                bursts_q[i] <= '0;
            conflict_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (done_q[i] && bursts_q[i] != 16'hFFFF)
                    bursts_q[i] <= bursts_q[i] + 16'd1;
            if (grant && ($countones(req) > 1) && conflict_q != 16'hFFFF)
                conflict_q <= conflict_q + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_bursts[g*16 +: 16] = bursts_q[g];
    end
    assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_shm_arbiter.sv
// tb_shm_arbiter: directed self-checking bench for shm_arbiter
// (NREQ=3, AW=6, DW=32, BURST=4, RD_LAT=1) with a behavioural SHM model.

module tb_shm_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 6;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   wr;
    logic [NREQ*AW-1:0] base_addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic              beat;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   rvalid;
    logic [DW-1:0]     rdata;
    logic              shm_ren;
    logic              shm_wen;
    logic [AW-1:0]     shm_addr;
    logic [DW-1:0]     shm_wdata;
    logic [DW-1:0]     shm_rdata;
`ifdef SHM_ARB_STATS_EN
    logic              stat_clr;
    logic [NREQ*16-1:0] stat_bursts;
    logic [15:0]       stat_conflict;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] rdq;

    shm_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .BURST(4), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr),
        .base_addr(base_addr), .wdata(wdata),
        .gnt(gnt), .beat(beat), .done(done),
        .rvalid(rvalid), .rdata(rdata),
        .shm_ren(shm_ren), .shm_wen(shm_wen),
        .shm_addr(shm_addr), .shm_wdata(shm_wdata),
        .shm_rdata(shm_rdata)
`ifdef SHM_ARB_STATS_EN
        ,
        .stat_clr(stat_clr), .stat_bursts(stat_bursts),
        .stat_conflict(stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    // SHM model: one-cycle read latency
    always @(posedge clk) begin
        if (shm_wen)
            mem[shm_addr] <= shm_wdata;
        if (shm_ren)
            rdq <= mem[shm_addr];
    end
    assign shm_rdata = rdq;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nxt();
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {gnt, beat, done, rvalid, shm_ren, shm_wen}, 64'd0);
        chk(tag, {rdata, shm_wdata}, 64'd0);
        chk(tag, shm_addr, 64'd0);
    endtask

`ifdef SHM_ARB_STATS_EN
    task automatic burst(input logic [2:0] r, input logic [2:0] exp_g);
        int cnt;
        nxt();
        req = r;
        wr  = r;
        #4;
        cnt = 0;
        while (gnt == 0 && cnt < 20) begin
            nxt();
            #4;
            cnt++;
        end
        chk("st_gnt", gnt, exp_g);
        req = '0;
        cnt = 0;
        while (done == 0 && cnt < 20) begin
            nxt();
            #4;
            cnt++;
        end
        chk("st_done", done, exp_g);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] a;
        logic [2:0] eg;
        reset     = 1'b1;
        req       = '0;
        wr        = '0;
        base_addr = '0;
        wdata     = '0;
`ifdef SHM_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        #2;
        chk_zero("rst");
        nxt();
        nxt();
        reset = 1'b0;

        // single write with address wrap, requester 0
        nxt();
        req = 3'b001;
        wr  = 3'b001;
        base_addr[0 +: 6] = 6'h3E;
        wdata[0 +: 32] = 32'hA0;
        #4;
        chk("t1_nognt", gnt, 0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            wdata[0 +: 32] = 32'hA0 + k;
            #4;
            a = 6'h3E + 6'(k);
            chk("t1_gnt", gnt, 3'b001);
            chk("t1_wen", {shm_wen, shm_ren}, 2'b10);
            chk("t1_addr", shm_addr, a);
            chk("t1_wdata", shm_wdata, 32'hA0 + k);
        end
        nxt();
        req = '0;
        #4;
        chk("t1_done", done, 3'b001);
        chk("t1_gclr", {gnt, beat}, 0);
        for (int k = 0; k < 4; k++) begin
            a = 6'h3E + 6'(k);
            chk("t1_mem", mem[a], 32'hA0 + k);
        end

        // early drop: requester 2 writes 11,22,33,44 at 0x10
        nxt();
        req = 3'b100;
        wr  = 3'b100;
        base_addr[12 +: 6] = 6'h10;
        wdata[64 +: 32] = 32'h11;
        #4;
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (k == 2)
                req = '0;
            wdata[64 +: 32] = 32'h11 * (k + 1);
            #4;
            chk("t4_beat", {beat, shm_wen}, 2'b11);
            chk("t4_gnt", gnt, 3'b100);
            chk("t4_addr", shm_addr, 6'h10 + k);
        end
        nxt();
        #4;
        chk("t4_done", done, 3'b100);
        for (int k = 0; k < 4; k++)
            chk("t4_mem", mem[6'h10 + k], 32'h11 * (k + 1));

        // single read, requester 1
        nxt();
        req = 3'b010;
        wr  = 3'b000;
        base_addr[6 +: 6] = 6'h10;
        #4;
        for (int c = 1; c <= 7; c++) begin
            nxt();
            if (c == 7)
                req = '0;
            #4;
            chk("t2_ren", shm_ren, c <= 4);
            if (c <= 4)
                chk("t2_addr", shm_addr, 6'h10 + c - 1);
            chk("t2_gnt", gnt, (c <= 6) ? 3'b010 : 3'b000);
            chk("t2_rvalid", rvalid, (c >= 3 && c <= 6) ? 3'b010 : 3'b000);
            if (c >= 3 && c <= 6)
                chk("t2_rdata", rdata, 32'h11 * (c - 2));
            chk("t2_done", done, (c == 7) ? 3'b010 : 3'b000);
        end

        // contention, all three held
        do_reset();
        nxt();
        req = 3'b111;
        wr  = 3'b111;
        base_addr = '0;
        wdata = '0;
        #4;
        for (int c = 1; c <= 20; c++) begin
            nxt();
            if (c == 20)
                req = '0;
            #4;
            eg = ((c - 1) % 5 < 4) ? 3'(1 << (((c - 1) / 5) % 3)) : 3'b000;
            chk("t3_gnt", gnt, eg);
            eg = (c % 5 == 0) ? 3'(1 << ((c / 5 - 1) % 3)) : 3'b000;
            chk("t3_done", done, eg);
            chk("t3_excl", shm_ren & shm_wen, 0);
        end

        // reset in the middle of a read burst
        do_reset();
        nxt();
        req = 3'b001;
        wr  = 3'b000;
        base_addr[0 +: 6] = 6'h10;
        #4;
        nxt();
        nxt();
        nxt();
        reset = 1'b1;
        req = '0;
        #4;
        chk_zero("t5_rst");
        nxt();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            nxt();
            #4;
            chk("t5_quiet", {gnt, done, rvalid}, 0);
        end
        nxt();
        req = 3'b001;
        wr  = 3'b001;
        #4;
        chk("t5_nognt", gnt, 0);
        nxt();
        req = '0;
        #4;
        chk("t5_gnt", gnt, 3'b001);
        for (int c = 1; c <= 4; c++) begin
            nxt();
            #4;
        end
        chk("t5_done", done, 3'b001);

`ifdef SHM_ARB_STATS_EN
        do_reset();
        burst(3'b001, 3'b001);
        burst(3'b001, 3'b001);
        burst(3'b001, 3'b001);
        burst(3'b011, 3'b010);
        nxt();
        #4;
        chk("st_b0", stat_bursts[15:0], 3);
        chk("st_b1", stat_bursts[31:16], 1);
        chk("st_conf", stat_conflict, 1);
        nxt();
        stat_clr = 1'b1;
        #4;
        nxt();
        stat_clr = 1'b0;
        #4;
        chk("st_clr", {stat_bursts, stat_conflict}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
